// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate generator, control decoder, load-use hazard and ID/EX register.
// Optional macro RF_WB_BYPASS_EN: register reads see a same-cycle writeback.
module decode_stage #(
    parameter int unsigned BITS   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BITS-1:0]   IF_ID_Inst,
    input  logic [BITS-1:0]   IF_ID_PC,
    input  logic [BITS-1:0]   IF_ID_PC_INC,
    input  logic              IF_ID_HLT,
    input  logic              FLUSH,
    input  logic              LWCP_STALL,
    input  logic              WB_reg_wr,
    input  logic [REG_AW-1:0] WB_rd,
    input  logic [BITS-1:0]   WB_data,
    output logic              STALL,
    output logic [BITS-1:0]   ID_EX_rs1_data,
    output logic [BITS-1:0]   ID_EX_rs2_data,
    output logic [BITS-1:0]   ID_EX_imm,
    output logic [REG_AW-1:0] ID_EX_rs1,
    output logic [REG_AW-1:0] ID_EX_rs2,
    output logic [REG_AW-1:0] ID_EX_rd,
    output logic [2:0]        ID_EX_funct3,
    output logic              ID_EX_funct7b5,
    output logic [6:0]        ID_EX_opcode,
    output logic [BITS-1:0]   ID_EX_PC,
    output logic [BITS-1:0]   ID_EX_PC_INC,
    output logic              ID_EX_reg_wr,
    output logic              ID_EX_mem_rd,
    output logic              ID_EX_mem_wr,
    output logic              ID_EX_alu_src,
    output logic              ID_EX_branch,
    output logic              ID_EX_jump,
    output logic              ID_EX_HLT,
    output logic [1:0]        ID_EX_wb_sel
);

    localparam int unsigned NREG = 2 ** REG_AW;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [BITS-1:0]   rs1_data;
        logic [BITS-1:0]   rs2_data;
        logic [BITS-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic [6:0]        opcode;
        logic [BITS-1:0]   pc;
        logic [BITS-1:0]   pc_inc;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
        logic              alu_src;
        logic              branch;
        logic              jump;
        logic              hlt;
        logic [1:0]        wb_sel;
    } id_ex_t;

    function automatic id_ex_t bubble_f();
        id_ex_t b;
        b        = '0;
        b.opcode = OP_IMM;
        b.pc_inc = BITS'(4);
        return b;
    endfunction

    logic [BITS-1:0]   rf_mem [NREG];
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1_idx;
    logic [REG_AW-1:0] rs2_idx;
    logic [BITS-1:0]   rs1_rd;
    logic [BITS-1:0]   rs2_rd;
    logic              rs1_used;
    logic              rs2_used;
    logic              stall_c;
    id_ex_t            dec;
    id_ex_t            id_ex_d;
    id_ex_t            id_ex_q;

    assign opcode  = IF_ID_Inst[6:0];
    assign rs1_idx = REG_AW'(IF_ID_Inst[19:15]);
    assign rs2_idx = REG_AW'(IF_ID_Inst[24:20]);

    // Register file storage is intentionally not reset; x0 is never written.
    always_ff @(posedge clk) begin
        if (WB_reg_wr && (WB_rd != '0)) begin
            rf_mem[WB_rd] <= WB_data;
        end
    end

    always_comb begin
        rs1_rd = (rs1_idx == '0) ? '0 : rf_mem[rs1_idx];
        rs2_rd = (rs2_idx == '0) ? '0 : rf_mem[rs2_idx];
`ifdef RF_WB_BYPASS_EN
        if (WB_reg_wr && (WB_rd != '0) && (WB_rd == rs1_idx)) rs1_rd = WB_data;
        if (WB_reg_wr && (WB_rd != '0) && (WB_rd == rs2_idx)) rs2_rd = WB_data;
`else
`endif
    end

    // Main decoder and immediate generator.
    always_comb begin
        dec          = '0;
        dec.rs1_data = rs1_rd;
        dec.rs2_data = rs2_rd;
        dec.rs1      = rs1_idx;
        dec.rs2      = rs2_idx;
        dec.rd       = REG_AW'(IF_ID_Inst[11:7]);
        dec.funct3   = IF_ID_Inst[14:12];
        dec.funct7b5 = IF_ID_Inst[30];
        dec.opcode   = opcode;
        dec.pc       = IF_ID_PC;
        dec.pc_inc   = IF_ID_PC_INC;
        dec.hlt      = IF_ID_HLT;
        rs1_used     = 1'b1;
        rs2_used     = 1'b0;
        case (opcode)
            OP_R: begin
                dec.reg_wr = 1'b1;
                rs2_used   = 1'b1;
            end
            OP_IMM: begin
                dec.reg_wr  = 1'b1;
                dec.alu_src = 1'b1;
                dec.imm     = {{(BITS-12){IF_ID_Inst[31]}}, IF_ID_Inst[31:20]};
            end
            OP_LOAD: begin
                dec.reg_wr  = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.alu_src = 1'b1;
                dec.wb_sel  = 2'd1;
                dec.imm     = {{(BITS-12){IF_ID_Inst[31]}}, IF_ID_Inst[31:20]};
            end
            OP_STORE: begin
                dec.mem_wr  = 1'b1;
                dec.alu_src = 1'b1;
                rs2_used    = 1'b1;
                dec.imm     = {{(BITS-12){IF_ID_Inst[31]}}, IF_ID_Inst[31:25], IF_ID_Inst[11:7]};
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                rs2_used   = 1'b1;
                dec.imm    = {{(BITS-13){IF_ID_Inst[31]}}, IF_ID_Inst[31], IF_ID_Inst[7],
                              IF_ID_Inst[30:25], IF_ID_Inst[11:8], 1'b0};
            end
            OP_JAL: begin
                dec.reg_wr = 1'b1;
                dec.jump   = 1'b1;
                dec.wb_sel = 2'd2;
                rs1_used   = 1'b0;
                dec.imm    = {{(BITS-21){IF_ID_Inst[31]}}, IF_ID_Inst[31], IF_ID_Inst[19:12],
                              IF_ID_Inst[20], IF_ID_Inst[30:21], 1'b0};
            end
            OP_JALR: begin
                dec.reg_wr  = 1'b1;
                dec.jump    = 1'b1;
                dec.alu_src = 1'b1;
                dec.wb_sel  = 2'd2;
                dec.imm     = {{(BITS-12){IF_ID_Inst[31]}}, IF_ID_Inst[31:20]};
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_wr  = 1'b1;
                dec.alu_src = 1'b1;
                rs1_used    = 1'b0;
                dec.imm     = {{(BITS-32){IF_ID_Inst[31]}}, IF_ID_Inst[31:12], 12'b0};
            end
            default: begin
            end
        endcase
    end

    // Load-use hazard against the instruction currently in EX.
    assign stall_c = ~FLUSH && id_ex_q.mem_rd && (id_ex_q.rd != '0) &&
                     ((rs1_used && (rs1_idx == id_ex_q.rd)) ||
                      (rs2_used && (rs2_idx == id_ex_q.rd)));
    assign STALL   = stall_c;

    always_comb begin
        id_ex_d = id_ex_q;
        if (LWCP_STALL) begin
            id_ex_d = id_ex_q;
        end else if (FLUSH || stall_c) begin
            id_ex_d = bubble_f();
        end else begin
            id_ex_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex_q <= bubble_f();
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ID_EX_rs1_data = id_ex_q.rs1_data;
    assign ID_EX_rs2_data = id_ex_q.rs2_data;
    assign ID_EX_imm      = id_ex_q.imm;
    assign ID_EX_rs1      = id_ex_q.rs1;
    assign ID_EX_rs2      = id_ex_q.rs2;
    assign ID_EX_rd       = id_ex_q.rd;
    assign ID_EX_funct3   = id_ex_q.funct3;
    assign ID_EX_funct7b5 = id_ex_q.funct7b5;
    assign ID_EX_opcode   = id_ex_q.opcode;
    assign ID_EX_PC       = id_ex_q.pc;
    assign ID_EX_PC_INC   = id_ex_q.pc_inc;
    assign ID_EX_reg_wr   = id_ex_q.reg_wr;
    assign ID_EX_mem_rd   = id_ex_q.mem_rd;
    assign ID_EX_mem_wr   = id_ex_q.mem_wr;
    assign ID_EX_alu_src  = id_ex_q.alu_src;
    assign ID_EX_branch   = id_ex_q.branch;
    assign ID_EX_jump     = id_ex_q.jump;
    assign ID_EX_HLT      = id_ex_q.hlt;
    assign ID_EX_wb_sel   = id_ex_q.wb_sel;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random traffic
// checked against a behavioural model of the decode stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, hlt, flush, lwcp, wb_en;
    logic [31:0] inst, pc, pc_inc, wb_data;
    logic [4:0]  wb_rd;

    logic        STALL;
    logic [31:0] ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_PC, ID_EX_PC_INC;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [2:0]  ID_EX_funct3;
    logic        ID_EX_funct7b5;
    logic [6:0]  ID_EX_opcode;
    logic        ID_EX_reg_wr, ID_EX_mem_rd, ID_EX_mem_wr, ID_EX_alu_src;
    logic        ID_EX_branch, ID_EX_jump, ID_EX_HLT;
    logic [1:0]  ID_EX_wb_sel;

    always #5 clk = ~clk;

    decode_stage #(.BITS(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .IF_ID_Inst(inst), .IF_ID_PC(pc), .IF_ID_PC_INC(pc_inc),
        .IF_ID_HLT(hlt), .FLUSH(flush), .LWCP_STALL(lwcp), .WB_reg_wr(wb_en), .WB_rd(wb_rd),
        .WB_data(wb_data), .STALL(STALL), .ID_EX_rs1_data(ID_EX_rs1_data),
        .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1),
        .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd), .ID_EX_funct3(ID_EX_funct3),
        .ID_EX_funct7b5(ID_EX_funct7b5), .ID_EX_opcode(ID_EX_opcode), .ID_EX_PC(ID_EX_PC),
        .ID_EX_PC_INC(ID_EX_PC_INC), .ID_EX_reg_wr(ID_EX_reg_wr), .ID_EX_mem_rd(ID_EX_mem_rd),
        .ID_EX_mem_wr(ID_EX_mem_wr), .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_branch(ID_EX_branch),
        .ID_EX_jump(ID_EX_jump), .ID_EX_HLT(ID_EX_HLT), .ID_EX_wb_sel(ID_EX_wb_sel)
    );

    typedef struct packed {
        logic [31:0] rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [6:0]  opcode;
        logic [31:0] pc, pc_inc;
        logic        reg_wr, mem_rd, mem_wr, alu_src, branch, jump, hlt;
        logic [1:0]  wb_sel;
    } ex_t;

    int          total = 0;
    int          bad   = 0;
    ex_t         exp_q;
    ex_t         saved;
    logic [31:0] rf_m [32];
    bit          known = 1'b0;
    logic        exp_stall;
    logic        stall_seen;
    logic [31:0] old_val;
    logic [31:0] r;
    logic [6:0]  ops [12];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ex_t got();
        ex_t g;
        g.rs1_data = ID_EX_rs1_data; g.rs2_data = ID_EX_rs2_data; g.imm = ID_EX_imm;
        g.rs1 = ID_EX_rs1; g.rs2 = ID_EX_rs2; g.rd = ID_EX_rd;
        g.funct3 = ID_EX_funct3; g.funct7b5 = ID_EX_funct7b5; g.opcode = ID_EX_opcode;
        g.pc = ID_EX_PC; g.pc_inc = ID_EX_PC_INC;
        g.reg_wr = ID_EX_reg_wr; g.mem_rd = ID_EX_mem_rd; g.mem_wr = ID_EX_mem_wr;
        g.alu_src = ID_EX_alu_src; g.branch = ID_EX_branch; g.jump = ID_EX_jump;
        g.hlt = ID_EX_HLT; g.wb_sel = ID_EX_wb_sel;
        return g;
    endfunction

    function automatic ex_t bubble();
        ex_t b = '0;
        b.opcode = 7'h13;
        b.pc_inc = 32'd4;
        return b;
    endfunction

    // Architectural register read as seen during decode.
    function automatic logic [31:0] rd_reg(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef RF_WB_BYPASS_EN
        if (wb_en && wb_rd == idx) return wb_data;
`endif
        return rf_m[idx];
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op == 7'h33 || op == 7'h23 || op == 7'h63;
    endfunction

    function automatic ex_t model_decode();
        ex_t e = '0;
        int  si = int'(inst);
        logic [31:0] imm_i = 32'(si >>> 20);
        e.opcode = inst[6:0]; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
        e.funct3 = inst[14:12]; e.funct7b5 = inst[30];
        e.pc = pc; e.pc_inc = pc_inc; e.hlt = hlt;
        e.rs1_data = rd_reg(inst[19:15]);
        e.rs2_data = rd_reg(inst[24:20]);
        case (inst[6:0])
            7'h33: e.reg_wr = 1'b1;
            7'h13: begin e.reg_wr = 1'b1; e.alu_src = 1'b1; e.imm = imm_i; end
            7'h03: begin e.reg_wr = 1'b1; e.mem_rd = 1'b1; e.alu_src = 1'b1; e.wb_sel = 2'd1; e.imm = imm_i; end
            7'h23: begin
                e.mem_wr = 1'b1; e.alu_src = 1'b1;
                e.imm = (32'(si >>> 25) << 5) | 32'(inst[11:7]);
            end
            7'h63: begin
                e.branch = 1'b1;
                e.imm = (32'(si >>> 31) << 12) | (32'(inst[7]) << 11) |
                        (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
            end
            7'h6F: begin
                e.reg_wr = 1'b1; e.jump = 1'b1; e.wb_sel = 2'd2;
                e.imm = (32'(si >>> 31) << 20) | (32'(inst[19:12]) << 12) |
                        (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
            end
            7'h67: begin e.reg_wr = 1'b1; e.jump = 1'b1; e.alu_src = 1'b1; e.wb_sel = 2'd2; e.imm = imm_i; end
            7'h37, 7'h17: begin e.reg_wr = 1'b1; e.alu_src = 1'b1; e.imm = inst & 32'hFFFFF000; end
            default: begin end
        endcase
        return e;
    endfunction

    // One clock: check the combinational stall, advance the model, check the latched ID/EX.
    task automatic step();
        ex_t nxt;
        #1;
        exp_stall = !flush && exp_q.mem_rd && exp_q.rd != 5'd0 &&
                    ((uses_rs1(inst[6:0]) && inst[19:15] == exp_q.rd) ||
                     (uses_rs2(inst[6:0]) && inst[24:20] == exp_q.rd));
        stall_seen = STALL;
        if (known) chk("stall", 256'(STALL), 256'(exp_stall));
        if (!rst_n)                   nxt = bubble();
        else if (lwcp)                nxt = exp_q;
        else if (flush || exp_stall)  nxt = bubble();
        else                          nxt = model_decode();
        if (wb_en && wb_rd != 5'd0) rf_m[wb_rd] = wb_data;
        @(posedge clk);
        #1;
        exp_q = nxt;
        known = 1'b1;
        chk("idex", 256'(got()), 256'(exp_q));
    endtask

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h03, 7'h00};
        rst_n = 1'b0; inst = '0; pc = '0; pc_inc = 32'd4; hlt = 1'b0;
        flush = 1'b0; lwcp = 1'b0; wb_en = 1'b1; wb_rd = '0; wb_data = '0;
        rf_m[0] = '0;
        @(posedge clk);
        #1;

        // Reset held while the register file is filled with known values.
        for (int i = 1; i < 32; i++) begin
            wb_rd = 5'(i);
            wb_data = $urandom();
            step();
        end
        chk("rst_stall", 256'(STALL), 256'(0));
        chk("rst_pc_inc", 256'(ID_EX_PC_INC), 256'(32'd4));
        chk("rst_opcode", 256'(ID_EX_opcode), 256'(7'h13));
        wb_en = 1'b0;
        rst_n = 1'b1;

        // addi x1,x0,-1
        inst = 32'hFFF00093; pc = 32'h100; pc_inc = 32'h104;
        step();
        chk("addi_imm", 256'(ID_EX_imm), 256'(32'hFFFFFFFF));
        chk("addi_rd", 256'(ID_EX_rd), 256'(5'd1));
        chk("addi_ctl", 256'({ID_EX_reg_wr, ID_EX_alu_src, ID_EX_wb_sel}), 256'(4'b1100));

        // lw x5,0(x2) then add x6,x5,x1
        inst = 32'h00012283; step();
        inst = 32'h00128333; step();
        chk("lu_stall1", 256'(stall_seen), 256'(1));
        chk("lu_bubble", 256'({ID_EX_reg_wr, ID_EX_opcode}), 256'({1'b0, 7'h13}));
        step();
        chk("lu_stall2", 256'(stall_seen), 256'(0));
        chk("lu_issue_rs1", 256'(ID_EX_rs1), 256'(5'd5));

        // Same-cycle writeback of x7 while decoding add x8,x7,x0
        old_val = rf_m[7];
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF; inst = 32'h00038433;
        step();
`ifdef RF_WB_BYPASS_EN
        chk("wb_bypass", 256'(ID_EX_rs1_data), 256'(32'hDEADBEEF));
`else
        chk("wb_nobypass", 256'(ID_EX_rs1_data), 256'(old_val));
`endif
        wb_rd = 5'd0; wb_data = 32'h1234; inst = 32'h00000433;
        step();
        chk("x0_zero", 256'(ID_EX_rs1_data), 256'(0));
        wb_en = 1'b0; inst = 32'h00038433;
        step();
        chk("x7_after", 256'(ID_EX_rs1_data), 256'(32'hDEADBEEF));

        // FLUSH with jal, then FLUSH over a load-use pair
        inst = 32'h008000EF; flush = 1'b1;
        step();
        chk("flush_jump", 256'(ID_EX_jump), 256'(0));
        flush = 1'b0; inst = 32'h00012283; step();
        inst = 32'h00128333; flush = 1'b1; step();
        chk("flush_nostall", 256'(stall_seen), 256'(0));
        flush = 1'b0;

        // Coprocessor stall holds ID/EX while IF/ID changes
        inst = 32'h00500193; step();
        saved = got();
        lwcp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst = $urandom(); pc = $urandom(); pc_inc = pc + 32'd4;
            step();
            chk("lwcp_hold", 256'(got()), 256'(saved));
        end
        lwcp = 1'b0; inst = 32'h00128333;
        step();
        chk("lwcp_release", 256'(ID_EX_opcode), 256'(7'h33));

        // Random traffic; fetch keeps IF/ID while a hazard stall is raised.
        stall_seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!stall_seen) begin
                r = $urandom();
                inst = r;
                inst[6:0]   = ops[$urandom_range(0, 11)];
                inst[11:7]  = 5'($urandom_range(0, 7));
                inst[19:15] = 5'($urandom_range(0, 7));
                inst[24:20] = 5'($urandom_range(0, 7));
                pc = $urandom(); pc_inc = pc + 32'd4;
                hlt = ($urandom_range(0, 4) == 0);
            end
            flush   = ($urandom_range(0, 9) == 0);
            lwcp    = ($urandom_range(0, 9) == 0);
            wb_en   = $urandom_range(0, 1) == 1;
            wb_rd   = 5'($urandom_range(0, 7));
            wb_data = $urandom();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I DECODE pipeline stage; consumes the IF/ID register outputs of the fetch stage and produces the ID/EX pipeline register.
- Contains the 32x32 register file, immediate generator and main control decoder.
- Detects load-use hazards and drives the global STALL back to fetch.
- Inserts bubbles on FLUSH or hazard; holds all state on LWCP_STALL.

Parameters:
BITS, 32, datapath width
REG_AW, 5, register-file address width (2**REG_AW registers)

Ports:
clk  in  1  global clock
rst_n  in  1  synchronous active-low reset
IF_ID_Inst  in  BITS  instruction from fetch
IF_ID_PC  in  BITS  PC of instruction
IF_ID_PC_INC  in  BITS  PC+4
IF_ID_HLT  in  1  halt flag from fetch
FLUSH  in  1  branch/jump taken in EX; squash this stage
LWCP_STALL  in  1  coprocessor global stall
WB_reg_wr  in  1  writeback enable
WB_rd  in  REG_AW  writeback destination
WB_data  in  BITS  writeback data
STALL  out  1  load-use hazard stall (combinational)
ID_EX_rs1_data, ID_EX_rs2_data  out  BITS  register operands
ID_EX_imm  out  BITS  sign-extended immediate
ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out  REG_AW  register indices (for forwarding)
ID_EX_funct3  out  3  instruction funct3
ID_EX_funct7b5  out  1  Inst[30]
ID_EX_opcode  out  7  opcode
ID_EX_PC, ID_EX_PC_INC  out  BITS  pipelined PCs
ID_EX_reg_wr, ID_EX_mem_rd, ID_EX_mem_wr, ID_EX_alu_src, ID_EX_branch, ID_EX_jump, ID_EX_HLT  out  1  control
ID_EX_wb_sel  out  2  0 ALU, 1 MEM, 2 PC_INC

Behaviour:
- Clock/reset: single clock clk; reset rst_n is synchronous, active-low.
- Register file: 2 async read ports, 1 sync write port on posedge clk when WB_reg_wr && WB_rd!=0.
  - x0 always reads 0.
  - Register contents are not reset.
- Immediates, Inst-sliced and sign-extended to BITS:
  - I: Inst[31:20], used by OP-IMM, LOAD, JALR.
  - S: {Inst[31:25], Inst[11:7]}.
  - B: {Inst[31], Inst[7], Inst[30:25], Inst[11:8], 0}.
  - U: {Inst[31:12], 12'b0}, used by LUI, AUIPC.
  - J: {Inst[31], Inst[19:12], Inst[20], Inst[30:21], 0}.
  - R-type and other opcodes: imm=0.
- Control decode:
  - R (0110011): reg_wr.
  - OP-IMM (0010011): reg_wr, alu_src.
  - LOAD (0000011): reg_wr, mem_rd, alu_src, wb_sel=1.
  - STORE (0100011): mem_wr, alu_src.
  - BRANCH (1100011): branch.
  - JAL (1101111): reg_wr, jump, wb_sel=2.
  - JALR (1100111): reg_wr, jump, alu_src, wb_sel=2.
  - LUI / AUIPC: reg_wr, alu_src.
  - ECALL (1110011): all controls 0, HLT passes.
  - Any other opcode: all controls 0.
- rs_used flags:
  - rs1 used by all except LUI, AUIPC, JAL.
  - rs2 used by R, STORE, BRANCH.
- Hazard: STALL = ID_EX_mem_rd && ID_EX_rd!=0 && ((rs1_used && rs1==ID_EX_rd) || (rs2_used && rs2==ID_EX_rd)).
  - STALL is forced 0 when FLUSH=1.
- ID/EX register update, priority order:
  1. ~rst_n: bubble.
  2. LWCP_STALL: hold all ID/EX outputs.
  3. FLUSH: bubble.
  4. STALL: bubble; the IF/ID contents are held by fetch, so the instruction re-decodes next cycle.
  5. Otherwise: load the decoded values.
- Bubble definition:
  - All control bits 0, HLT=0, wb_sel=0.
  - opcode=0010011, rd=rs1=rs2=0, imm=0, data=0.
  - PC=0, PC_INC=4.
  - This is also the reset value of every ID/EX output.
- Latency: one cycle from IF_ID_* to ID_EX_*.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined: a read port returns WB_data when WB_reg_wr && WB_rd!=0 && WB_rd equals that port's index (write-before-read in the same cycle).
- Undefined: reads return the pre-write array value; the downstream forwarding unit must cover the WB->ID distance.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all ID_EX_* equal the bubble values, STALL=0.
- IF_ID_Inst=0xFFF00093 (addi x1,x0,-1) -> next cycle ID_EX_imm=0xFFFFFFFF, rd=1, reg_wr=1, alu_src=1, wb_sel=0.
- lw x5,0(x2), then add x6,x5,x1 -> STALL=1 for exactly one cycle, ID_EX gets a bubble; the add then issues with rs1=5.
- WB write x7=0xDEADBEEF while decoding add x8,x7,x0 -> ID_EX_rs1_data=0xDEADBEEF with RF_WB_BYPASS_EN; old value without it. A write to x0 with 0x1234 -> x0 still reads 0.
- FLUSH=1 with a valid jal in IF/ID -> bubble latched, ID_EX_jump=0; FLUSH together with a load-use condition -> STALL=0.
- LWCP_STALL=1 for 3 cycles while IF/ID changes -> ID_EX outputs unchanged; they update on the first cycle after release.
